// File: rtl/oreg_drain.sv
`default_nettype none
// ============================================================================
// oreg_drain : snapshots one systolic column's partial sums on cap and
//              streams them out row 0 first over valid/ready.
// Revision   : 1.0
// ============================================================================
module oreg_drain #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   cap,
  input  logic [DEPTH*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_last,
  output logic                   busy,
  output logic                   ovf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_n;
  logic [WIDTH-1:0] shadow [DEPTH];
  logic             load;
  logic             ovf_set;
  logic             at_last;
  logic             xfer;

  assign at_last = (idx == LAST_IDX);
  assign xfer    = (state == DRAIN) && o_ready;

  // Every output is decoded from registered state only.
  assign o_valid = (state == DRAIN);
  assign o_last  = (state == DRAIN) && at_last;
  assign busy    = (state == DRAIN);
  assign o_data  = shadow[idx];

  always_comb begin
    state_n = state;
    idx_n   = idx;
    load    = 1'b0;
    ovf_set = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          load    = 1'b1;
          idx_n   = '0;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && at_last) begin
          // A capture coinciding with the final handshake chains the next tile.
          if (cap) begin
            load  = 1'b1;
            idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_n = idx + IDX_W'(1);
          end
          if (cap) begin
            ovf_set = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      idx   <= '0;
      ovf   <= 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        shadow[r] <= '0;
      end
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (ovf_set) begin
        ovf <= 1'b1;
      end
      if (load) begin
        for (int r = 0; r < DEPTH; r++) begin
          shadow[r] <= i_data[r*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oreg_drain.sv
`default_nettype none
// Scoreboard bench for oreg_drain: rows queued on cap, popped on each handshake.
module tb_oreg_drain;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clr;
  logic                   cap;
  logic [DEPTH*WIDTH-1:0] i_data;
  logic [WIDTH-1:0]       o_data;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_last;
  logic                   busy;
  logic                   ovf;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [DEPTH*WIDTH-1:0] tile_a;
  logic [DEPTH*WIDTH-1:0] tile_b;
  logic [DEPTH*WIDTH-1:0] tile_c;

  oreg_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .cap     (cap),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic push_tile(input logic [DEPTH*WIDTH-1:0] d);
    exp_t e;
    for (int r = 0; r < DEPTH; r++) begin
      e.data = d[r*WIDTH +: WIDTH];
      e.last = (r == DEPTH - 1);
      sb.push_back(e);
    end
  endtask

  // Called at a falling edge: the capture is sampled on the next rising edge.
  task automatic drive_cap(input logic [DEPTH*WIDTH-1:0] d);
    i_data = d;
    cap    = 1'b1;
    push_tile(d);
  endtask

  task automatic scramble;
    i_data = {$urandom, $urandom};
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; cap = 1'b0; o_ready = 1'b0; i_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", o_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0000", o_data); end
  endtask

  task automatic test_basic;
    int cyc = 0;
    o_ready = 1'b1;
    drive_cap(tile_a);
    @(negedge clk);
    cap = 1'b0; scramble();
    while (sb.size() > 0 && cyc < 20) begin
      checks++; if (o_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_valid cyc %0d got v=%b b=%b want 1", cyc, o_valid, busy); end
      checks++; if (o_data !== sb[0].data) begin errors++; $display("FAIL basic_data cyc %0d got %h want %h", cyc, o_data, sb[0].data); end
      checks++; if (o_last !== sb[0].last) begin errors++; $display("FAIL basic_last cyc %0d got %b want %b", cyc, o_last, sb[0].last); end
      void'(sb.pop_front());
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != DEPTH || sb.size() != 0) begin errors++; $display("FAIL basic_cycles got %0d left %0d want %0d left 0", cyc, sb.size(), DEPTH); end
    checks++; if (o_valid !== 1'b0 || busy !== 1'b0 || o_last !== 1'b0) begin errors++; $display("FAIL basic_idle got v=%b b=%b l=%b want 000", o_valid, busy, o_last); end
    sb.delete();
  endtask

  task automatic test_backpressure;
    int cyc = 0;
    int accepted = 0;
    o_ready = 1'b1;
    drive_cap(tile_a);
    @(negedge clk);
    cap = 1'b0; scramble();
    while (sb.size() > 0 && cyc < 20) begin
      o_ready = !(cyc == 1 || cyc == 2);
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b want 1", cyc, o_valid); end
      checks++; if (o_data !== sb[0].data) begin errors++; $display("FAIL bp_data cyc %0d got %h want %h", cyc, o_data, sb[0].data); end
      checks++; if (o_last !== sb[0].last) begin errors++; $display("FAIL bp_last cyc %0d got %b want %b", cyc, o_last, sb[0].last); end
      if (o_ready) begin
        void'(sb.pop_front());
        accepted++;
      end
      @(negedge clk);
      cyc++;
    end
    o_ready = 1'b1;
    checks++; if (cyc != DEPTH + 2 || accepted != DEPTH) begin errors++; $display("FAIL bp_cycles got %0d/%0d want %0d/%0d", cyc, accepted, DEPTH + 2, DEPTH); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", o_valid); end
    sb.delete();
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    bit chained = 0;
    o_ready = 1'b1;
    drive_cap(tile_a);
    @(negedge clk);
    cap = 1'b0; scramble();
    while (sb.size() > 0 && cyc < 30) begin
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc %0d got %b want 1", cyc, o_valid); end
      checks++; if (o_data !== sb[0].data) begin errors++; $display("FAIL b2b_data cyc %0d got %h want %h", cyc, o_data, sb[0].data); end
      checks++; if (o_last !== sb[0].last) begin errors++; $display("FAIL b2b_last cyc %0d got %b want %b", cyc, o_last, sb[0].last); end
      if (sb[0].last && !chained) begin
        void'(sb.pop_front());
        drive_cap(tile_b);
        chained = 1;
      end else begin
        void'(sb.pop_front());
        cap = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    cap = 1'b0;
    checks++; if (cyc != 2 * DEPTH) begin errors++; $display("FAIL b2b_cycles got %0d want %0d", cyc, 2 * DEPTH); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", ovf); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", o_valid); end
    sb.delete();
  endtask

  task automatic test_dropped;
    int cyc = 0;
    o_ready = 1'b1;
    drive_cap(tile_a);
    @(negedge clk);
    cap = 1'b0; scramble();
    while (sb.size() > 0 && cyc < 20) begin
      if (cyc == 1) begin
        i_data = tile_c;
        cap    = 1'b1;
      end else begin
        cap = 1'b0;
      end
      if (cyc >= 2) begin
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL drop_ovf cyc %0d got %b want 1", cyc, ovf); end
      end
      checks++; if (o_data !== sb[0].data) begin errors++; $display("FAIL drop_data cyc %0d got %h want %h", cyc, o_data, sb[0].data); end
      checks++; if (o_last !== sb[0].last) begin errors++; $display("FAIL drop_last cyc %0d got %b want %b", cyc, o_last, sb[0].last); end
      void'(sb.pop_front());
      @(negedge clk);
      cyc++;
    end
    cap = 1'b0;
    checks++; if (cyc != DEPTH || o_valid !== 1'b0) begin errors++; $display("FAIL drop_end got cyc=%0d v=%b want %0d v=0", cyc, o_valid, DEPTH); end
    repeat (3) @(negedge clk);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b want 1", ovf); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL drop_clr got %b want 0", ovf); end
    sb.delete();
  endtask

  task automatic test_reset_mid(input bit use_clr);
    o_ready = 1'b1;
    drive_cap(tile_a);
    @(negedge clk);
    cap = 1'b0; scramble();
    @(negedge clk);
    cap = 1'b1;
    @(negedge clk);
    checks++; if (ovf !== 1'b1 || o_valid !== 1'b1) begin errors++; $display("FAIL abort_pre clr=%0d got ovf=%b v=%b want 1 1", use_clr, ovf, o_valid); end
    if (use_clr) clr = 1'b1; else rst = 1'b1;
    i_data = tile_c;
    cap    = 1'b1;
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; cap = 1'b0;
    checks++; if (o_valid !== 1'b0 || busy !== 1'b0 || o_last !== 1'b0) begin errors++; $display("FAIL abort_ctl clr=%0d got v=%b b=%b l=%b want 000", use_clr, o_valid, busy, o_last); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL abort_data clr=%0d got %h want 0000", use_clr, o_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf clr=%0d got %b want 0", use_clr, ovf); end
    @(negedge clk);
    checks++; if (o_valid !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL abort_capign clr=%0d got v=%b ovf=%b want 0 0", use_clr, o_valid, ovf); end
    sb.delete();
  endtask

  task automatic test_idle;
    for (int i = 0; i < 50; i++) begin
      o_ready = 1'($urandom_range(0, 1));
      i_data  = {$urandom, $urandom};
      @(negedge clk);
      checks++; if (o_valid !== 1'b0 || o_last !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ctl cyc %0d got v=%b l=%b b=%b want 000", i, o_valid, o_last, busy); end
      checks++; if (o_data !== '0) begin errors++; $display("FAIL idle_data cyc %0d got %h want 0000", i, o_data); end
    end
  endtask

  initial begin
    tile_a = {16'h8000, 16'h7FFF, 16'hFFFE, 16'h0011};
    tile_b = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tile_c = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h1234};
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_dropped();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
